// File: rtl/strait_pkg.sv
// Shared defaults, helpers and test_mode encoding for the array edge buffers and BIST.
package strait_pkg;

    localparam int DEF_SYSTOLIC_SIZE    = 8;
    localparam int DEF_PSUM_WIDTH       = 24;
    localparam int DEF_ACTIVATION_WIDTH = 8;

    localparam logic TEST_MODE_DESKEW = 1'b0;
    localparam logic TEST_MODE_BYPASS = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/psum_sync_fifo.sv
// Single-clock FIFO for aligned result rows; head is zero while empty.
module psum_sync_fifo
    import strait_pkg::*;
#(
    parameter int WIDTH = 192,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             wr_en;
    logic             rd_en;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop frees the slot the same cycle, so a full FIFO still accepts a push alongside it.
    assign wr_en = push & (~full | pop);
    assign rd_en = pop & ~empty;

    assign dout = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_en};
        if (wr_en) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/output_deskew_buffer.sv
// Removes the per-column skew of the array's bottom row and queues aligned rows
// for a valid/ready consumer; test_mode bypasses the deskew for raw BIST capture.
module output_deskew_buffer
    import strait_pkg::*;
#(
    parameter int SYSTOLIC_SIZE = DEF_SYSTOLIC_SIZE,
    parameter int PSUM_WIDTH    = DEF_PSUM_WIDTH,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                test_mode,
    input  logic [SYSTOLIC_SIZE*PSUM_WIDTH-1:0] psum_in_flat,
    input  logic                                psum_in_valid,
    output logic [SYSTOLIC_SIZE*PSUM_WIDTH-1:0] out_data_flat,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                out_last,
    output logic                                overflow
);

    localparam int VW    = SYSTOLIC_SIZE * PSUM_WIDTH;
    localparam int VLD_N = SYSTOLIC_SIZE - 1;
    localparam int CNT_W = clog2(SYSTOLIC_SIZE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYSTOLIC_SIZE - 1);

    logic             mode_q, mode_d;
    logic [VLD_N-1:0] vld_q, vld_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [VW-1:0]    aligned_flat;
    logic [VW-1:0]    push_data;
    logic             mode_chg;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;

    assign mode_chg = (test_mode != mode_q);

    // Column j needs SYSTOLIC_SIZE-1-j stages so every column lands in the same cycle.
    for (genvar j = 0; j < SYSTOLIC_SIZE; j++) begin : g_col
        localparam int DEPTH_J = SYSTOLIC_SIZE - 1 - j;
        if (DEPTH_J == 0) begin : g_thru
            assign aligned_flat[j*PSUM_WIDTH +: PSUM_WIDTH] = psum_in_flat[j*PSUM_WIDTH +: PSUM_WIDTH];
        end else begin : g_dly
            logic [PSUM_WIDTH-1:0] pipe_q [DEPTH_J];
            logic [PSUM_WIDTH-1:0] pipe_d [DEPTH_J];

            always_comb begin
                pipe_d[0] = psum_in_flat[j*PSUM_WIDTH +: PSUM_WIDTH];
                for (int k = 1; k < DEPTH_J; k++) begin
                    pipe_d[k] = pipe_q[k-1];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    pipe_q <= '{default: '0};
                end else begin
                    pipe_q <= pipe_d;
                end
            end

            assign aligned_flat[j*PSUM_WIDTH +: PSUM_WIDTH] = pipe_q[DEPTH_J-1];
        end
    end

    always_comb begin
        mode_d   = test_mode;
        vld_d[0] = psum_in_valid & ~mode_chg;
        for (int k = 1; k < VLD_N; k++) begin
            vld_d[k] = vld_q[k-1] & ~mode_chg;
        end
    end

    // The tail valid is masked on a mode change too, so a row straddling the switch never lands.
    always_comb begin
        if (test_mode == TEST_MODE_BYPASS) begin
            push      = psum_in_valid;
            push_data = psum_in_flat;
        end else begin
            push      = vld_q[VLD_N-1] & ~mode_chg;
            push_data = aligned_flat;
        end
    end

    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;

    always_comb begin
        overflow_d = overflow_q | (push & fifo_full & ~pop);
        cnt_d      = cnt_q;
        if (pop) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= TEST_MODE_DESKEW;
            vld_q      <= '0;
            overflow_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            mode_q     <= mode_d;
            vld_q      <= vld_d;
            overflow_q <= overflow_d;
            cnt_q      <= cnt_d;
        end
    end

    assign overflow = overflow_q;
    assign out_last = out_valid & (cnt_q == CNT_LAST);

    psum_sync_fifo #(
        .WIDTH (VW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (push_data),
        .dout  (out_data_flat),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_output_deskew_buffer.sv
// Directed bench for output_deskew_buffer: skewed streams, backpressure, bypass, reset and mode toggles.
module tb_output_deskew_buffer;

    localparam int S  = 8;
    localparam int PW = 24;
    localparam int VW = S * PW;

    logic          clk;
    logic          rst;
    logic          test_mode;
    logic [VW-1:0] psum_in_flat;
    logic          psum_in_valid;
    logic [VW-1:0] out_data_flat;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          overflow;

    int checks;
    int errors;

    logic [VW-1:0] row_val [8];

    output_deskew_buffer #(
        .SYSTOLIC_SIZE (S),
        .PSUM_WIDTH    (PW),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .test_mode     (test_mode),
        .psum_in_flat  (psum_in_flat),
        .psum_in_valid (psum_in_valid),
        .out_data_flat (out_data_flat),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] mk_row(input int base, input int stp);
        logic [VW-1:0] v;
        v = '0;
        for (int j = 0; j < S; j++) begin
            v[j*PW +: PW] = PW'(base + j * stp);
        end
        return v;
    endfunction

    // Column j of row r is on the bus in cycle r+j.
    function automatic logic [VW-1:0] skew_flat(input int c, input int nrows);
        logic [VW-1:0] f;
        int r;
        f = '0;
        for (int j = 0; j < S; j++) begin
            r = c - j;
            if (r >= 0 && r < nrows) begin
                f[j*PW +: PW] = row_val[r][j*PW +: PW];
            end
        end
        return f;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_check(input string t, input int c, input logic ev, input logic [VW-1:0] ed,
                             input logic el, input logic eo);
        @(negedge clk);
        chk($sformatf("%s c%0d out_valid", t, c), VW'(out_valid), VW'(ev));
        chk($sformatf("%s c%0d out_last", t, c), VW'(out_last), VW'(el));
        chk($sformatf("%s c%0d overflow", t, c), VW'(overflow), VW'(eo));
        if (ev) begin
            chk($sformatf("%s c%0d data", t, c), out_data_flat, ed);
        end
    endtask

    task automatic zero_check(input string t);
        @(negedge clk);
        chk($sformatf("%s out_valid", t), VW'(out_valid), '0);
        chk($sformatf("%s out_last", t), VW'(out_last), '0);
        chk($sformatf("%s overflow", t), VW'(overflow), '0);
        chk($sformatf("%s data", t), out_data_flat, '0);
    endtask

    task automatic do_reset(input string t);
        step();
        rst           = 1'b1;
        test_mode     = 1'b0;
        psum_in_valid = 1'b0;
        psum_in_flat  = '0;
        out_ready     = 1'b0;
        step();
        rst = 1'b0;
        zero_check(t);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        test_mode     = 1'b0;
        psum_in_flat  = '0;
        psum_in_valid = 1'b0;
        out_ready     = 1'b0;

        do_reset("reset0");

        // Skewed ramp, consumer always ready.
        for (int r = 0; r < 8; r++) row_val[r] = mk_row(100 * r, 1);
        for (int c = 0; c <= 17; c++) begin
            step();
            psum_in_flat  = skew_flat(c, 8);
            psum_in_valid = (c < 8);
            out_ready     = 1'b1;
            cyc_check("ramp", c, (c >= 8 && c <= 15), mk_row(100 * (c - 8), 1), (c == 15), 1'b0);
        end

        do_reset("reset1");

        // Backpressure: five rows into a four-deep FIFO, the fifth is dropped.
        for (int r = 0; r < 5; r++) row_val[r] = mk_row(16 * (r + 1), 1);
        for (int c = 0; c <= 18; c++) begin
            step();
            psum_in_flat  = skew_flat(c, 5);
            psum_in_valid = (c < 5);
            out_ready     = (c >= 14);
            cyc_check("bp", c, (c >= 8 && c <= 17),
                      mk_row(16 * ((c <= 14) ? 1 : c - 13), 1), 1'b0, (c >= 12));
        end

        // Reset mid-stream; the counter was left at 4 and overflow set by the previous run.
        for (int r = 0; r < 8; r++) row_val[r] = mk_row(100 * r, 1);
        for (int c = 0; c <= 3; c++) begin
            step();
            psum_in_flat  = skew_flat(c, 8);
            psum_in_valid = 1'b1;
            out_ready     = 1'b1;
            rst           = (c == 3);
            cyc_check("rstmid", c, 1'b0, '0, 1'b0, 1'b1);
        end
        step();
        rst           = 1'b0;
        psum_in_valid = 1'b0;
        psum_in_flat  = '0;
        zero_check("rstmid c4");
        for (int r = 0; r < 8; r++) row_val[r] = mk_row(5000 + 100 * r, 1);
        for (int c = 0; c <= 17; c++) begin
            step();
            psum_in_flat  = skew_flat(c, 8);
            psum_in_valid = (c < 8);
            out_ready     = 1'b1;
            cyc_check("post_rst", c, (c >= 8 && c <= 15), mk_row(5000 + 100 * (c - 8), 1), (c == 15), 1'b0);
        end

        do_reset("reset2");

        // Full FIFO with a push and a pop in the same cycle.
        for (int r = 0; r < 4; r++) row_val[r] = mk_row(256 * (r + 1), 1);
        row_val[4] = mk_row(8'hAA, 0);
        for (int c = 0; c <= 16; c++) begin
            step();
            psum_in_flat  = skew_flat(c, 5);
            psum_in_valid = (c < 5);
            out_ready     = (c >= 11);
            cyc_check("fullpp", c, (c >= 8 && c <= 15),
                      (c == 15) ? mk_row(8'hAA, 0) : mk_row(256 * ((c <= 11) ? 1 : c - 10), 1),
                      1'b0, 1'b0);
        end

        do_reset("reset3");

        // Bypass: raw vector appears one cycle later, unskewed.
        for (int c = 0; c <= 3; c++) begin
            step();
            test_mode     = 1'b1;
            psum_in_valid = (c == 0);
            psum_in_flat  = (c == 0) ? mk_row(16, 1) : '0;
            out_ready     = 1'b1;
            cyc_check("bypass", c, (c == 1), mk_row(16, 1), 1'b0, 1'b0);
        end

        do_reset("reset4");

        // Mode toggles with rows in flight: only the bypass row may come out.
        for (int r = 0; r < 8; r++) row_val[r] = mk_row(100 * r, 1);
        for (int c = 0; c <= 16; c++) begin
            step();
            test_mode     = (c >= 3 && c <= 5);
            psum_in_valid = (c == 0) || (c == 5);
            psum_in_flat  = (c == 5) ? mk_row(8'h77, 0) : skew_flat(c, 1);
            out_ready     = 1'b1;
            cyc_check("toggle", c, (c == 6), mk_row(8'h77, 0), 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
